// File: rtl/store_buffer_fwd.sv
// Speculative + commit store queues with in-order D$ drain, tail write coalescing and store-to-load forwarding.
// Push/commit/drain are 1 cycle each; ready_o/commit_ready_o come from registered counts, mem_req_o holds until granted.
module store_buffer_fwd #(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8,
  parameter int unsigned PADDR_WIDTH  = 56,
  parameter int unsigned DATA_WIDTH   = 64,
  localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [PADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [BE_WIDTH-1:0]    be_i,
  input  logic [1:0]             size_i,
  output logic                   ready_o,
  input  logic                   commit_i,
  output logic                   commit_ready_o,
  output logic                   no_st_pending_o,
  input  logic                   ld_valid_i,
  input  logic [PADDR_WIDTH-1:0] ld_paddr_i,
  input  logic [BE_WIDTH-1:0]    ld_be_i,
  output logic                   fwd_valid_o,
  output logic [DATA_WIDTH-1:0]  fwd_data_o,
  output logic                   ld_stall_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [PADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_wdata_o,
  output logic [BE_WIDTH-1:0]    mem_be_o,
  output logic [1:0]             mem_size_o
);

  localparam int unsigned OFS = $clog2(BE_WIDTH);
  localparam int unsigned SPW = $clog2(SPEC_DEPTH);
  localparam int unsigned CPW = $clog2(COMMIT_DEPTH);
  localparam logic [SPW:0] SPEC_CAP   = (SPW+1)'(SPEC_DEPTH);
  localparam logic [CPW:0] COMMIT_CAP = (CPW+1)'(COMMIT_DEPTH);

  typedef struct packed {
    logic                   vld;
    logic [PADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]  data;
    logic [BE_WIDTH-1:0]    be;
    logic [1:0]             size;
  } sb_entry_t;

  sb_entry_t      spec_q   [SPEC_DEPTH];
  sb_entry_t      spec_d   [SPEC_DEPTH];
  sb_entry_t      commit_q [COMMIT_DEPTH];
  sb_entry_t      commit_d [COMMIT_DEPTH];
  logic [SPW-1:0] spec_wp_q, spec_wp_d, spec_rp_q, spec_rp_d;
  logic [SPW:0]   spec_cnt_q, spec_cnt_d;
  logic [CPW-1:0] commit_wp_q, commit_wp_d, commit_rp_q, commit_rp_d;
  logic [CPW:0]   commit_cnt_q, commit_cnt_d;

  logic           commit_go, push_go, gnt_go, merge, append;
  logic [CPW-1:0] commit_tail;
  sb_entry_t      cmt_e;
  sb_entry_t      head_e;

  assign ready_o         = spec_cnt_q < SPEC_CAP;
  assign commit_ready_o  = commit_cnt_q < COMMIT_CAP;
  assign no_st_pending_o = commit_cnt_q == '0;

  assign head_e      = commit_q[commit_rp_q];
  assign mem_req_o   = head_e.vld;
  assign mem_addr_o  = head_e.paddr;
  assign mem_wdata_o = head_e.data;
  assign mem_be_o    = head_e.be;
  assign mem_size_o  = head_e.size;

  // A full spec queue still takes a push when a commit frees the head slot in the same cycle.
  assign commit_go   = commit_i && (spec_cnt_q != '0) && commit_ready_o;
  assign push_go     = valid_i && !flush_i && (ready_o || commit_go);
  assign gnt_go      = mem_gnt_i && mem_req_o;
  assign cmt_e       = spec_q[spec_rp_q];
  assign commit_tail = commit_wp_q - CPW'(1);

  // Only coalesce when the tail is not the head already presented to the D$.
  assign merge  = commit_go && (commit_cnt_q >= (CPW+1)'(2)) && commit_q[commit_tail].vld &&
                  (commit_q[commit_tail].paddr[PADDR_WIDTH-1:OFS] == cmt_e.paddr[PADDR_WIDTH-1:OFS]);
  assign append = commit_go && !merge;

  always_comb begin
    spec_d     = spec_q;
    spec_wp_d  = spec_wp_q;
    spec_rp_d  = spec_rp_q;
    spec_cnt_d = spec_cnt_q;

    if (commit_go) begin
      spec_d[spec_rp_q] = '0;
      spec_rp_d         = spec_rp_q + SPW'(1);
    end
    if (push_go) begin
      spec_d[spec_wp_q] = '{vld: 1'b1, paddr: paddr_i, data: data_i, be: be_i, size: size_i};
      spec_wp_d         = spec_wp_q + SPW'(1);
    end
    if (push_go && !commit_go) begin
      spec_cnt_d = spec_cnt_q + (SPW+1)'(1);
    end else if (!push_go && commit_go) begin
      spec_cnt_d = spec_cnt_q - (SPW+1)'(1);
    end

    if (flush_i) begin
      for (int i = 0; i < SPEC_DEPTH; i++) begin
        spec_d[i] = '0;
      end
      spec_wp_d  = spec_rp_d;
      spec_cnt_d = '0;
    end
  end

  always_comb begin
    commit_d     = commit_q;
    commit_wp_d  = commit_wp_q;
    commit_rp_d  = commit_rp_q;
    commit_cnt_d = commit_cnt_q;

    if (gnt_go) begin
      commit_d[commit_rp_q] = '0;
      commit_rp_d           = commit_rp_q + CPW'(1);
    end
    if (merge) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (cmt_e.be[b]) begin
          commit_d[commit_tail].data[8*b +: 8] = cmt_e.data[8*b +: 8];
        end
      end
      commit_d[commit_tail].be   = commit_q[commit_tail].be | cmt_e.be;
      commit_d[commit_tail].size = 2'(OFS);
    end
    if (append) begin
      commit_d[commit_wp_q] = cmt_e;
      commit_wp_d           = commit_wp_q + CPW'(1);
    end
    if (append && !gnt_go) begin
      commit_cnt_d = commit_cnt_q + (CPW+1)'(1);
    end else if (!append && gnt_go) begin
      commit_cnt_d = commit_cnt_q - (CPW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SPEC_DEPTH; i++) begin
        spec_q[i] <= '0;
      end
      for (int i = 0; i < COMMIT_DEPTH; i++) begin
        commit_q[i] <= '0;
      end
      spec_wp_q    <= '0;
      spec_rp_q    <= '0;
      spec_cnt_q   <= '0;
      commit_wp_q  <= '0;
      commit_rp_q  <= '0;
      commit_cnt_q <= '0;
    end else begin
      spec_q       <= spec_d;
      commit_q     <= commit_d;
      spec_wp_q    <= spec_wp_d;
      spec_rp_q    <= spec_rp_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_wp_q  <= commit_wp_d;
      commit_rp_q  <= commit_rp_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  function automatic logic page_hit(input sb_entry_t e, input logic [11:OFS] pg,
                                    input logic [BE_WIDTH-1:0] be);
    return e.vld && (e.paddr[11:OFS] == pg) && (|(e.be & be));
  endfunction

  logic                   hit;
  logic [PADDR_WIDTH-1:0] hit_paddr;
  logic [DATA_WIDTH-1:0]  hit_data;
  logic [BE_WIDTH-1:0]    hit_be;
  logic                   st_clash;

  // Scan oldest to youngest so the last hit, i.e. the youngest matching store, wins.
  always_comb begin
    logic [SPW-1:0] sidx;
    logic [CPW-1:0] cidx;
    sidx      = '0;
    cidx      = '0;
    hit       = 1'b0;
    hit_paddr = '0;
    hit_data  = '0;
    hit_be    = '0;
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      cidx = commit_rp_q + CPW'(i);
      if (page_hit(commit_q[cidx], ld_paddr_i[11:OFS], ld_be_i)) begin
        hit       = 1'b1;
        hit_paddr = commit_q[cidx].paddr;
        hit_data  = commit_q[cidx].data;
        hit_be    = commit_q[cidx].be;
      end
    end
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      sidx = spec_rp_q + SPW'(i);
      if (page_hit(spec_q[sidx], ld_paddr_i[11:OFS], ld_be_i)) begin
        hit       = 1'b1;
        hit_paddr = spec_q[sidx].paddr;
        hit_data  = spec_q[sidx].data;
        hit_be    = spec_q[sidx].be;
      end
    end
  end

  assign st_clash = valid_i && (paddr_i[11:OFS] == ld_paddr_i[11:OFS]) && (|(be_i & ld_be_i));

  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_data_o  = '0;
    ld_stall_o  = 1'b0;
    if (ld_valid_i) begin
      if (st_clash) begin
        ld_stall_o = 1'b1;
      end else if (hit) begin
        if ((hit_paddr[PADDR_WIDTH-1:OFS] == ld_paddr_i[PADDR_WIDTH-1:OFS]) &&
            ((hit_be & ld_be_i) == ld_be_i)) begin
          fwd_valid_o = 1'b1;
          fwd_data_o  = hit_data;
        end else begin
          ld_stall_o = 1'b1;
        end
      end
    end
  end

  a_push_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (valid_i && !ready_o) |-> commit_i);
  a_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   commit_i |-> ((spec_cnt_q != '0) && commit_ready_o));
  a_flush_commit: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(flush_i && commit_i));

endmodule
